// File: rtl/rr_mux_if.sv
// rr_mux_if: valid/ready bundle for the N-input arbitrated mux and its single output.
// The slave side is the mux; the master side is the environment driving it.
interface rr_mux_if #(
    parameter int WIDTH = 32,
    parameter int N = 4
);
    localparam int SW = $clog2(N);
    logic [N-1:0] in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0] in_ready;
    logic out_valid;
    logic [WIDTH-1:0] out_data;
    logic [SW-1:0] out_src;
    logic out_ready;
    modport slave (
        input in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src
    );
    modport master (
        output in_valid, in_data, out_ready,
        input in_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/rr_mux.sv
// rr_mux: N-channel round-robin arbitrated mux with a one-entry registered output.
// Define RR_MUX_FIXED_PRIO_EN for fixed lowest-index-wins priority instead.
module rr_mux #(
    parameter int WIDTH = 32,
    parameter int N = 4
) (
    input logic clk,
    input logic reset,
    rr_mux_if.slave bus
);
    localparam int SW = $clog2(N);
    logic [SW-1:0] ptr;
    logic [SW-1:0] gnt;
    logic hit;
    logic can_load;
    logic xfer;
    // in_ready is forced low while reset is held so no word is taken during reset
    assign can_load = (!bus.out_valid || bus.out_ready) && !reset;
    assign xfer = hit && can_load;
    assign bus.in_ready = hit ? (N'(can_load) << gnt) : '0;
    always_comb begin
        int j;
        hit = 1'b0;
        gnt = '0;
        j = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!hit && bus.in_valid[j]) begin
                hit = 1'b1;
                gnt = SW'(j);
            end
        end
    end
`ifdef RR_MUX_FIXED_PRIO_EN
    assign ptr = '0;
`else
    always_ff @(posedge clk) begin
        if (reset) ptr <= '0;
        else if (xfer) ptr <= (gnt == SW'(N - 1)) ? '0 : gnt + 1'b1;
    end
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_data <= '0;
            bus.out_src <= '0;
        end else if (xfer) begin
            bus.out_valid <= 1'b1;
            bus.out_data <= bus.in_data[int'(gnt) * WIDTH +: WIDTH];
            bus.out_src <= gnt;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule
